// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron blocks: FSM state encoding,
// accumulator sizing and output saturation.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Wide enough for bias plus n full-scale products without overflow.
  function automatic int acc_width(input int x_w, input int w_w, input int n);
    return x_w + w_w + $clog2(n + 1) + 1;
  endfunction

  function automatic longint sat_signed(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic longint sat_unsigned(input longint v, input int w);
    longint hi;
    hi = (longint'(1) <<< w) - longint'(1);
    if (v < 0)       return 0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/nn_sat_act.sv
// Output stage: arithmetic right shift, then ReLU or linear saturation
// of the accumulator down to OUT_W bits.
module nn_sat_act
  import nn_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int OUT_W     = 10,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic                    relu_i,
  output logic        [OUT_W-1:0] y_o
);

  logic signed [ACC_W-1:0] s;
  longint                  s_l;
  longint                  y_l;

  // NOTE: combinational logic uses blocking assignments and assigns every
  // output on every path, so no latch can be inferred.
  always_comb begin
    s   = acc_i >>> OUT_SHIFT;
    s_l = longint'(s);
    y_l = relu_i ? sat_unsigned(s_l, OUT_W) : sat_signed(s_l, OUT_W);
    y_o = y_l[OUT_W-1:0];
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: accepts one operand set, performs one signed MAC per
// enabled cycle, then presents the activated, saturated result.
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int X_W       = 4,
  parameter int W_W       = 8,
  parameter int OUT_W     = 10,
  parameter int OUT_SHIFT = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N_IN*X_W-1:0]   x_i,
  input  logic [N_IN*W_W-1:0]   w_i,
  input  logic [W_W-1:0]        b_i,
  input  logic                  relu_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [OUT_W-1:0]      y_o,
  output logic                  busy_o
);

  localparam int ACC_W  = acc_width(X_W, W_W, N_IN);
  localparam int PROD_W = X_W + W_W + 1;
  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_e                   state_q;
  logic        [X_W-1:0]    x_q [N_IN];
  logic signed [W_W-1:0]    w_q [N_IN];
  logic                     relu_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic        [IDX_W-1:0]  idx_q;
  logic        [OUT_W-1:0]  y_q;
  logic        [OUT_W-1:0]  y_d;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] prod;
  logic                     accept;

  assign accept = (state_q == ST_IDLE) && in_valid_i;

  // NOTE: operand registers are plain storage loaded on accept, so they carry
  // no reset; only control state and visible outputs are reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < N_IN; i++) begin
        x_q[i] <= x_i[i*X_W +: X_W];
        w_q[i] <= w_i[i*W_W +: W_W];
      end
      relu_q <= relu_i;
    end
  end

  // x is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    x_ext = {{(W_W + 1){1'b0}}, x_q[idx_q]};
    w_ext = {{(X_W + 1){w_q[idx_q][W_W-1]}}, w_q[idx_q]};
    prod  = x_ext * w_ext;
    acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  end

  nn_sat_act #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_sat_act (
    .acc_i (acc_d),
    .relu_i(relu_q),
    .y_o   (y_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            acc_q   <= {{(ACC_W - W_W){b_i[W_W-1]}}, b_i};
            idx_q   <= '0;
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (en_i) begin
            acc_q <= acc_d;
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              y_q     <= y_d;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign y_o         = y_q;

endmodule
